// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch, load/store data) arbiter and
// sequencer in front of a single Memory access path. Round-robin grant on
// conflict, one outstanding transaction, one-cycle response pulse per port.
module mem_arbiter #(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned ADDR_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rsp_data,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_owner_d;     // 1: data port owns the transaction
   logic                r_last_d;      // 1: last grant went to the data port
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic [31:0]         r_if_rsp_data;
   logic [31:0]         r_d_rsp_data;
   logic                w_grant_if;
   logic                w_grant_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Grant decision, next state and all strobes/pulses
   always_comb begin
      w_next_state = r_state;
      w_grant_if   = 1'b0;
      w_grant_d    = 1'b0;
      if_req_ready = 1'b0;
      d_req_ready  = 1'b0;
      mem_wen      = 1'b0;
      mem_ren      = 1'b0;
      if_rsp_valid = 1'b0;
      d_rsp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_req_valid && d_req_valid) begin
               w_grant_if = r_last_d;
               w_grant_d  = !r_last_d;
            end else begin
               w_grant_if = if_req_valid;
               w_grant_d  = d_req_valid;
            end
            if_req_ready = w_grant_if;
            d_req_ready  = w_grant_d;
            if (w_grant_if || w_grant_d) begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_wen      = r_we;
            mem_ren      = !r_we;
            w_next_state = r_we ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            if_rsp_valid = !r_owner_d;
            d_rsp_valid  = r_owner_d;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Request latch, latency counter and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner_d     <= 1'b0;
         r_last_d      <= 1'b0;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_cnt         <= '0;
         r_if_rsp_data <= '0;
         r_d_rsp_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_d) begin
                  r_owner_d <= 1'b1;
                  r_last_d  <= 1'b1;
                  r_we      <= d_req_we;
                  r_addr    <= d_addr;
                  r_wdata   <= d_wdata;
               end else if (w_grant_if) begin
                  r_owner_d <= 1'b0;
                  r_last_d  <= 1'b0;
                  r_we      <= 1'b0;
                  r_addr    <= if_addr;
               end
            end
            ST_ACCESS: begin
               if (!r_we) begin
                  r_cnt <= CNT_W'(READ_LATENCY - 1);
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  if (r_owner_d) begin
                     r_d_rsp_data <= mem_rdata;
                  end else begin
                     r_if_rsp_data <= mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_waddr   = r_addr;
   assign mem_raddr   = r_addr;
   assign mem_wdata   = r_wdata;
   assign if_rsp_data = r_if_rsp_data;
   assign d_rsp_data  = r_d_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model (grant rule, fixed
// per-transaction timing offsets, associative-array memory).
module tb_mem_arbiter;

   localparam int RL = 3;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req_valid = 1'b0;
   logic          if_req_ready;
   logic [AW-1:0] if_addr = '0;
   logic          if_rsp_valid;
   logic [31:0]   if_rsp_data;
   logic          d_req_valid = 1'b0;
   logic          d_req_ready;
   logic          d_req_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [31:0]   d_wdata = '0;
   logic          d_rsp_valid;
   logic [31:0]   d_rsp_data;
   logic          mem_wen;
   logic          mem_ren;
   logic [AW-1:0] mem_waddr;
   logic [AW-1:0] mem_raddr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .READ_LATENCY (RL),
      .ADDR_W       (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_addr      (if_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_we     (d_req_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rsp_valid  (d_rsp_valid),
      .d_rsp_data   (d_rsp_data),
      .mem_wen      (mem_wen),
      .mem_ren      (mem_ren),
      .mem_waddr    (mem_waddr),
      .mem_raddr    (mem_raddr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   logic [31:0]   mem_m [int];
   int            m_next   = 0;
   bit            m_last_d = 1'b0;
   bit            m_act    = 1'b0;
   int            t_acc    = 0;
   bit            t_d      = 1'b0;
   bit            t_we     = 1'b0;
   logic [31:0]   t_rdata  = '0;
   logic [31:0]   t_wdata  = '0;
   logic [AW-1:0] m_addr   = '0;
   logic [31:0]   m_if_data = '0;
   logic [31:0]   m_d_data  = '0;
   bit            acc_if = 1'b0;
   bit            acc_d  = 1'b0;
   int            g_log[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
      if (mem_m.exists(int'(a))) return mem_m[int'(a)];
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // One clock cycle: inputs already driven by the caller (posedge + 1).
   task automatic step();
      bit free, e_if, e_d, e_ren, e_wen, e_ifv, e_dv;
      int rsp_at;
      free = (cyc >= m_next);
      e_if = 1'b0;
      e_d  = 1'b0;
      if (free) begin
         if (if_req_valid && d_req_valid) begin
            e_if = m_last_d;
            e_d  = !m_last_d;
         end else begin
            e_if = if_req_valid;
            e_d  = d_req_valid;
         end
      end
      rsp_at = t_acc + (t_we ? 2 : 2 + RL);
      e_ren  = m_act && !t_we && (cyc == t_acc + 1);
      e_wen  = m_act &&  t_we && (cyc == t_acc + 1);
      e_ifv  = m_act && !t_d && (cyc == rsp_at);
      e_dv   = m_act &&  t_d && (cyc == rsp_at);
      if (m_act && !t_we && cyc == rsp_at) begin
         if (t_d) m_d_data = t_rdata;
         else     m_if_data = t_rdata;
      end
      mem_rdata = (m_act && !t_we && cyc == t_acc + 1 + RL) ? t_rdata : $urandom();
      #1;
      if (!rst) begin
         check("if_req_ready", 32'(if_req_ready), 32'(e_if));
         check("d_req_ready",  32'(d_req_ready),  32'(e_d));
         check("mem_ren",      32'(mem_ren),      32'(e_ren));
         check("mem_wen",      32'(mem_wen),      32'(e_wen));
         check("mem_raddr",    32'(mem_raddr),    32'(m_addr));
         check("mem_waddr",    32'(mem_waddr),    32'(m_addr));
         check("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
         check("d_rsp_valid",  32'(d_rsp_valid),  32'(e_dv));
         check("if_rsp_data",  if_rsp_data,       m_if_data);
         check("d_rsp_data",   d_rsp_data,        m_d_data);
         if (e_wen) check("mem_wdata", mem_wdata, t_wdata);
      end
      acc_if = 1'b0;
      acc_d  = 1'b0;
      if (rst) begin
         m_next    = cyc + 1;
         m_last_d  = 1'b0;
         m_act     = 1'b0;
         m_addr    = '0;
         m_if_data = '0;
         m_d_data  = '0;
      end else begin
         if (if_req_valid && if_req_ready)     g_log.push_back(0);
         else if (d_req_valid && d_req_ready)  g_log.push_back(1);
         if (e_if || e_d) begin
            t_acc    = cyc;
            t_d      = e_d;
            t_we     = e_d ? d_req_we : 1'b0;
            m_addr   = e_d ? d_addr : if_addr;
            t_wdata  = d_wdata;
            t_rdata  = t_we ? 32'h0 : mem_rd(m_addr);
            if (t_we) mem_m[int'(m_addr)] = d_wdata;
            m_last_d = e_d;
            m_act    = 1'b1;
            m_next   = cyc + (t_we ? 3 : 3 + RL);
            acc_if   = e_if;
            acc_d    = e_d;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_reset(input int n);
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic req_if(input logic [AW-1:0] a);
      if_req_valid = 1'b1;
      if_addr      = a;
      for (int k = 0; k < 40; k++) begin
         step();
         if (acc_if) break;
      end
      check("if_accept_in_time", 32'(acc_if), 32'd1);
      if_req_valid = 1'b0;
   endtask

   task automatic req_d(input bit we, input logic [AW-1:0] a, input logic [31:0] wd);
      d_req_valid = 1'b1;
      d_req_we    = we;
      d_addr      = a;
      d_wdata     = wd;
      for (int k = 0; k < 40; k++) begin
         step();
         if (acc_d) break;
      end
      check("d_accept_in_time", 32'(acc_d), 32'd1);
      d_req_valid = 1'b0;
   endtask

   // Random requester behaviour: hold payload until accepted, occasional drop.
   task automatic rnd_drive();
      if (if_req_valid && !acc_if) begin
         if ($urandom_range(0, 7) == 0) if_req_valid = 1'b0;
      end else begin
         if_req_valid = ($urandom_range(0, 1) == 1);
         if_addr      = AW'($urandom_range(0, 63));
      end
      if (d_req_valid && !acc_d) begin
         if ($urandom_range(0, 7) == 0) d_req_valid = 1'b0;
      end else begin
         d_req_valid = ($urandom_range(0, 1) == 1);
         d_req_we    = ($urandom_range(0, 1) == 1);
         d_addr      = AW'($urandom_range(0, 63));
         d_wdata     = $urandom();
      end
   endtask

   initial begin
      int n0, if_cyc, d_cyc, k;
      mem_m[16'h0010] = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      do_reset(2);

      // fetch-only read
      req_if(16'h0010);
      idle(RL + 4);
      check("if_read_data", if_rsp_data, 32'hDEAD_BEEF);

      // store then load back through the data port
      req_d(1'b1, 16'h0200, 32'h1234_5678);
      req_d(1'b0, 16'h0200, 32'h0);
      idle(RL + 4);
      check("d_load_data", d_rsp_data, 32'h1234_5678);

      // continuous conflict after reset alternates starting with data
      do_reset(1);
      g_log.delete();
      if_req_valid = 1'b1;
      if_addr      = 16'h0044;
      d_req_valid  = 1'b1;
      d_req_we     = 1'b0;
      d_addr       = 16'h0088;
      for (k = 0; k < 200 && g_log.size() < 6; k++) step();
      idle(RL + 4);
      check("conflict_grants", 32'(g_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < g_log.size(); i++)
         check("conflict_order", 32'(g_log[i]), ((i % 2) == 0) ? 32'd1 : 32'd0);

      // reset while a read waits: no response, round-robin restarts at data
      req_if(16'h0030);
      step();
      do_reset(1);
      idle(RL + 4);
      g_log.delete();
      if_req_valid = 1'b1;
      d_req_valid  = 1'b1;
      d_req_we     = 1'b1;
      d_addr       = 16'h0034;
      d_wdata      = 32'hCAFE_F00D;
      for (k = 0; k < 20 && g_log.size() < 1; k++) step();
      d_req_valid = 1'b0;
      check("reset_conflict_first", (g_log.size() > 0) ? 32'(g_log[0]) : 32'hFFFF_FFFF, 32'd1);
      for (k = 0; k < 40 && !acc_if; k++) step();
      if_req_valid = 1'b0;
      idle(RL + 4);

      // data request raised during a fetch's memory access waits for idle
      if_req_valid = 1'b1;
      if_addr      = 16'h0010;
      for (k = 0; k < 40 && !acc_if; k++) step();
      if_cyc       = cyc - 1;
      if_req_valid = 1'b0;
      d_req_valid  = 1'b1;
      d_req_we     = 1'b1;
      d_addr       = 16'h0300;
      d_wdata      = 32'h0BAD_CAFE;
      d_cyc        = -1;
      for (k = 0; k < 40; k++) begin
         step();
         if (acc_d) begin
            d_cyc = cyc - 1;
            break;
         end
      end
      d_req_valid = 1'b0;
      check("backpressure_accept_cycle", 32'(d_cyc - if_cyc), 32'(3 + RL));
      idle(RL + 4);

      // randomized traffic with occasional resets
      n0 = checks;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1);
            acc_if = 1'b0;
            acc_d  = 1'b0;
         end else begin
            rnd_drive();
            step();
         end
      end
      idle(RL + 5);
      check("random_phase_ran", 32'(checks > n0 + 1000), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
